// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave with a byte FIFO feeding an 8N1 UART
// transmitter (LSB first, idle-high line).
//
// Register map, decoded on addr_i[3:2]:
//   0 TXDATA  write pushes data_i[7:0]; a write while full is dropped and sets
//             the sticky overflow flag. Reads return 0.
//   1 STATUS  read: [0] full, [1] empty, [2] busy, [3] overflow, [15:8] level.
//             write: data_i[3]=1 clears overflow.
//   2, 3      acknowledged; reads return 0, writes have no effect.
//
// Bus handshake: cyc_i & stb_i is the request (valid). A request seen while
// ack_o is low is accepted on that rising edge: every side effect commits on
// that edge, and ack_o (ready/response) is high for exactly the following
// cycle. ack_o then drops for at least one cycle, so a master that holds its
// strobe is acknowledged at most every second cycle. data_o carries read data
// only while ack_o is high and is 0 otherwise.
module wb_uart_tx #(
    parameter int CLK_FRE    = 27,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        tx_o,
    output logic        busy_o
);

    // Clock cycles per UART bit.
    localparam int CPB   = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

    // Serializer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus-side registers.
    logic        ack_q;
    logic [31:0] data_q, data_d;
    logic        ovf_q, ovf_d;

    // FIFO storage and bookkeeping.
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Serializer registers.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic        req;
    logic [1:0]  reg_sel;
    logic        wr_txdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        bit_last;
    logic [31:0] status;

    // Address and data bits that the register map never looks at.
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

    assign req        = cyc_i & stb_i & ~ack_q;
    assign reg_sel    = addr_i[3:2];
    assign wr_txdata  = req & we_i & (reg_sel == 2'd0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    // A simultaneous pop frees a slot on the same edge, so a full FIFO still
    // takes the byte in that case.
    assign push       = wr_txdata & (~fifo_full | pop);
    assign bit_last   = (cnt_q == CNT_LAST);

    assign status = {16'h0000, 8'(level_q), 4'h0, ovf_q, busy_o, fifo_empty, fifo_full};

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign tx_o   = tx_q;
    assign busy_o = (state_q != ST_IDLE);

    // Register reads, overflow flag and FIFO pointer/level next state.
    always_comb begin
        data_d   = 32'h0;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (req && !we_i && reg_sel == 2'd1) begin
            data_d = status;
        end

        if (wr_txdata && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (req && we_i && reg_sel == 2'd1 && data_i[3]) begin
            ovf_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Serializer next state; tx is decoded from the current state and
    // registered, so the line lags the state by one clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_last) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[idx_q];
                if (bit_last) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d = 1'b1;
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // FIFO storage; reset only needs to clear the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    // Bus response, flags and FIFO bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            data_q   <= 32'h0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            ack_q    <= req;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Serializer state and the registered line output (idle high on reset).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: bench for wb_uart_tx at its default parameters
// (CPB = 234, FIFO_DEPTH = 16). Bytes written to TXDATA are queued as
// expected frames; a line monitor pops and compares each frame it sees.
module tb_wb_uart_tx;

    localparam int CPB   = 234;
    localparam int FRAME = 10 * CPB;
    localparam int GAP   = FRAME + 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr_i = 32'h0;
    logic        we_i = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        tx_o;
    logic        busy_o;

    wb_uart_tx dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .addr_i (addr_i),
        .we_i   (we_i),
        .data_i (data_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .data_o (data_o),
        .ack_o  (ack_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frames_done = 0;
    logic       mon_en = 1'b0;
    int         last_ack_cyc = 0;

    // Line monitor: on a start bit, compare every cycle of the 10-bit frame
    // against the popped expected byte.
    initial begin : frame_mon
        logic [9:0] obs;
        logic [9:0] expf;
        logic [7:0] b;
        int         bad;
        forever begin
            @(negedge clk_i);
            if (mon_en && rst_i === 1'b0 && tx_o === 1'b0) begin
                start_q.push_back(cyc_cnt);
                obs = '0;
                bad = 0;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 32'd1, 32'd0);
                    b = 8'h00;
                end else begin
                    b = exp_q.pop_front();
                end
                expf = {1'b1, b, 1'b0};
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk_i);
                    if (tx_o !== expf[c / CPB]) bad++;
                    if (c % CPB == CPB / 2) obs[c / CPB] = tx_o;
                end
                check("frame_bits", 32'(obs), 32'(expf));
                check("frame_shape", bad, 0);
                frames_done++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All bus tasks start and end on a falling edge.
    task automatic wb_xfer(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
        int waited;
        waited = 0;
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = wdata;
        do begin
            @(negedge clk_i);
            waited++;
        end while (ack_o !== 1'b1 && waited < 8);
        check("ack_seen", 32'(ack_o), 32'd1);
        rdata        = data_o;
        last_ack_cyc = cyc_cnt;
        cyc_i  = 1'b0;
        stb_i  = 1'b0;
        we_i   = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, addr, wdata, unused_rd);
    endtask

    task automatic wb_read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, addr, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        wb_write(32'h0, {24'h0, b});
    endtask

    task automatic wait_frames(input int n, input int budget);
        int spent;
        spent = 0;
        while (frames_done < n && spent < budget) begin
            @(negedge clk_i);
            spent++;
        end
        check("frames_done", frames_done, n);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [5:0] pat;
        int         ack0;
        int         lows;
        int         spent;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk_i);
        check("rst_tx_during", 32'(tx_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", data_o, 32'h0);
        @(negedge clk_i);
        wb_read_check("rst_status", 32'h4, 32'h0000_0002);
        @(negedge clk_i);
        check("data_after_ack", data_o, 32'h0);

        // Held strobe: ack toggles every other cycle; unmapped read is 0.
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'hC;
        #1;
        pat = {5'b0, ack_o};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            pat = {pat[4:0], ack_o};
            if (ack_o) check("rd_addr_c", data_o, 32'h0);
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        check("ack_pattern", 32'(pat), 32'b010101);
        @(negedge clk_i);
        wb_read_check("rd_txdata", 32'h0, 32'h0);
        wb_write(32'h8, 32'hFFFF_FFFF);
        wb_read_check("status_after_ignored", 32'h4, 32'h0000_0002);

        // Single byte 0x55.
        mon_en = 1'b1;
        start_q.delete();
        send_byte(8'h55);
        ack0 = last_ack_cyc;
        wait_frames(1, FRAME + 200);
        if (start_q.size() > 0) check("tx_latency", start_q[0] - ack0, 2);
        else check("tx_latency_missing", 32'd0, 32'd1);
        repeat (2) @(negedge clk_i);
        check("busy_after_frame", 32'(busy_o), 32'd0);

        // Burst of three back-to-back writes.
        start_q.delete();
        frames_done = 0;
        send_byte(8'h41);
        ack0 = last_ack_cyc;
        send_byte(8'h42);
        send_byte(8'h43);
        wb_read_check("burst_status", 32'h4, 32'h0000_0204);
        wait_frames(3, 3 * GAP + 200);
        if (start_q.size() == 3) begin
            check("burst_latency", start_q[0] - ack0, 2);
            check("burst_gap1", start_q[1] - start_q[0], GAP);
            check("burst_gap2", start_q[2] - start_q[1], GAP);
        end else begin
            check("burst_starts", start_q.size(), 3);
        end
        repeat (3) @(negedge clk_i);
        wb_read_check("status_drained", 32'h4, 32'h0000_0002);

        // Overflow with the serializer busy, then reset mid-frame.
        mon_en = 1'b0;
        wb_write(32'h0, 32'h0000_0000);
        ack0 = last_ack_cyc;
        for (int i = 0; i < 18; i++) begin
            wb_write(32'h0, 32'($urandom_range(1, 255)));
        end
        wb_read_check("ovf_status", 32'h4, 32'h0000_100D);
        wb_write(32'h4, 32'h0000_0008);
        wb_read_check("ovf_cleared", 32'h4, 32'h0000_1005);

        spent = 0;
        while (cyc_cnt < ack0 + 2 + 4 * CPB + CPB / 2 && spent < 2 * FRAME) begin
            @(negedge clk_i);
            spent++;
        end
        check("data_bit3_low", 32'(tx_o), 32'd0);
        check("busy_mid_frame", 32'(busy_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx_o), 32'd1);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        wb_read_check("post_rst_status", 32'h4, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < FRAME + 500; i++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
        end
        check("no_resume", lows, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
